// File: rtl/skew_delay_stream_pkg.sv
// skew_delay_stream_pkg: lane direction type and per-lane delay helper for the skew/deskew array.
package skew_delay_stream_pkg;
  typedef enum logic {SKEW_DIR_DESKEW, SKEW_DIR_SKEW} skew_dir_e;
  function automatic int skew_lane_delay(int c, int sa, int base, skew_dir_e dir);
    return base + (dir == SKEW_DIR_DESKEW ? sa - 1 - c : c);
  endfunction
  function automatic int skew_cnt_w(int sa, int base);
    return $clog2(sa * (base + sa - 1) + 1);
  endfunction
endpackage

// File: rtl/skew_delay_stream_if.sv
// skew_delay_stream_if: per-lane valid/data stream with a single shared ready in each direction.
interface skew_delay_stream_if
  import skew_delay_stream_pkg::*;
#(
  parameter int SA_SIZE = 8,
  parameter int DATA_W = 32,
  parameter int BASE_LATENCY = 1
);
  localparam int CNT_W = skew_cnt_w(SA_SIZE, BASE_LATENCY);
  logic [SA_SIZE-1:0] in_valid;
  logic [DATA_W-1:0] in_data [SA_SIZE];
  logic in_ready;
  logic [SA_SIZE-1:0] out_valid;
  logic [DATA_W-1:0] out_data [SA_SIZE];
  logic out_ready;
  logic [CNT_W-1:0] pending;
  logic busy;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, pending, busy
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, pending, busy
  );
endinterface

// File: rtl/skew_delay_stream_lane.sv
// skew_delay_lane: one lane's valid+data shift register, advancing only when en is high.
module skew_delay_lane #(
  parameter int DEPTH = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [DATA_W-1:0] d [DEPTH];
  logic [DATA_W-1:0] d_in;
  assign d_in = in_valid ? in_data : '0;
  always_ff @(posedge clk)
    if (!resetn) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (en) begin
      v <= DEPTH'({v, in_valid});
      d[0] <= d_in;
      for (int k = 1; k < DEPTH; k++) d[k] <= d[k-1];
    end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/skew_delay_stream.sv
// skew_delay_stream: per-lane skew/deskew delay array with whole-array stall and occupancy count.
module skew_delay_stream
  import skew_delay_stream_pkg::*;
#(
  parameter int SA_SIZE = 8,
  parameter int DATA_W = 32,
  parameter int BASE_LATENCY = 1,
  parameter skew_dir_e DIR = SKEW_DIR_DESKEW
) (
  input logic clk,
  input logic resetn,
  skew_delay_stream_if.slave s
);
  localparam int CNT_W = skew_cnt_w(SA_SIZE, BASE_LATENCY);
  logic adv;
  logic [CNT_W-1:0] pending;
  if (BASE_LATENCY < 1) begin : g_bad_latency
    $error("skew_delay_stream: BASE_LATENCY must be >= 1");
  end
  if (SA_SIZE < 1) begin : g_bad_size
    $error("skew_delay_stream: SA_SIZE must be >= 1");
  end
  assign adv = s.out_ready | ~(|s.out_valid);
  assign s.in_ready = adv;
  for (genvar c = 0; c < SA_SIZE; c++) begin : g_lane
    skew_delay_lane #(
      .DEPTH (skew_lane_delay(c, SA_SIZE, BASE_LATENCY, DIR)),
      .DATA_W(DATA_W)
    ) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .en       (adv),
      .in_valid (s.in_valid[c]),
      .in_data  (s.in_data[c]),
      .out_valid(s.out_valid[c]),
      .out_data (s.out_data[c])
    );
  end
  // Entries and exits in the same advance net out; the count never exceeds the total stage count.
  always_ff @(posedge clk)
    if (!resetn) pending <= '0;
    else pending <= pending + CNT_W'($countones(s.in_valid & {SA_SIZE{adv}}))
                            - CNT_W'($countones(s.out_valid & {SA_SIZE{adv}}));
  assign s.pending = pending;
  assign s.busy = |pending;
  a_valid_pending: assert property (@(posedge clk) disable iff (!resetn) |s.out_valid |-> pending != '0);
endmodule

// File: tb/tb_skew_delay_stream.sv
// tb_skew_delay_stream: directed checks of deskew/skew timing, backpressure, bubbles, reset and drain.
module tb_skew_delay_stream;
  import skew_delay_stream_pkg::*;
  logic clk = 0;
  logic resetn = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  skew_delay_stream_if #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(1)) if_des ();
  skew_delay_stream_if #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(1)) if_skw ();
  skew_delay_stream_if #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(3)) if_b3 ();
  skew_delay_stream #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(1), .DIR(SKEW_DIR_DESKEW))
    u_des (.clk(clk), .resetn(resetn), .s(if_des));
  skew_delay_stream #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(1), .DIR(SKEW_DIR_SKEW))
    u_skw (.clk(clk), .resetn(resetn), .s(if_skw));
  skew_delay_stream #(.SA_SIZE(4), .DATA_W(8), .BASE_LATENCY(3), .DIR(SKEW_DIR_DESKEW))
    u_b3 (.clk(clk), .resetn(resetn), .s(if_b3));

  function automatic int dly(int c, bit skew, int base);
    return base + (skew ? c : 3 - c);
  endfunction

  // Occupancy after a advances of an all-valid stream of nv vectors, no stalls inside the stream.
  function automatic int exp_pend(int a, int nv, bit skew, int base);
    int sum = 0;
    for (int c = 0; c < 4; c++) begin
      int acc;
      int em;
      acc = a < nv ? a : nv;
      em = a - dly(c, skew, base);
      em = em < 0 ? 0 : (em > nv ? nv : em);
      sum += acc - em;
    end
    return sum;
  endfunction

  task automatic idle();
    if_des.in_valid = '0; if_des.out_ready = 1;
    if_skw.in_valid = '0; if_skw.out_ready = 1;
    if_b3.in_valid = '0; if_b3.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if_des.in_data[c] = '0; if_skw.in_data[c] = '0; if_b3.in_data[c] = '0;
    end
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    @(posedge clk); #1;
    if_des.out_ready = 0;
    #1;
    n_chk++;
    if (if_des.out_valid !== 4'h0 || if_des.pending !== 5'd0 || if_des.busy !== 1'b0 || if_des.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_des: got v=%b pend=%0d busy=%b rdy=%b, want v=0000 pend=0 busy=0 rdy=1",
               if_des.out_valid, if_des.pending, if_des.busy, if_des.in_ready);
    end
    n_chk++;
    if (if_skw.out_valid !== 4'h0 || if_skw.pending !== 5'd0 || if_b3.out_valid !== 4'h0 || if_b3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_others: got skw v=%b pend=%0d b3 v=%b busy=%b, want zeros",
               if_skw.out_valid, if_skw.pending, if_b3.out_valid, if_b3.busy);
    end
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (if_des.out_data[c] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_data lane %0d: got %h want 00", c, if_des.out_data[c]);
      end
    end
    resetn = 1;
    if_des.out_ready = 1;
  endtask

  task automatic test_deskew_stream();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      if_des.in_valid = 4'hF;
      for (int c = 0; c < 4; c++) if_des.in_data[c] = 8'(16 * c + t);
      #1;
      for (int c = 0; c < 4; c++) begin
        int src;
        logic ev;
        logic [7:0] ed;
        src = t - dly(c, 0, 1);
        ev = src >= 0;
        ed = ev ? 8'(16 * c + src) : 8'h00;
        n_chk++;
        if (if_des.out_valid[c] !== ev || if_des.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL deskew t=%0d lane %0d: got v=%b d=%h, want v=%b d=%h",
                   t, c, if_des.out_valid[c], if_des.out_data[c], ev, ed);
        end
      end
      n_chk++;
      if (if_des.pending !== 5'(exp_pend(t, 100, 0, 1))) begin
        n_fail++;
        $display("FAIL deskew_pending t=%0d: got %0d want %0d", t, if_des.pending, exp_pend(t, 100, 0, 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_skew_single();
    do_reset();
    for (int t = 0; t < 6; t++) begin
      logic [3:0] evv;
      int ep;
      if_skw.in_valid = t == 0 ? 4'hF : 4'h0;
      for (int c = 0; c < 4; c++) if_skw.in_data[c] = 8'(8'hA0 + c);
      #1;
      evv = (t >= 1 && t <= 4) ? 4'(1 << (t - 1)) : 4'h0;
      ep = t == 0 ? 0 : 5 - t;
      n_chk++;
      if (if_skw.out_valid !== evv || if_skw.pending !== 5'(ep) || if_skw.busy !== (ep != 0)) begin
        n_fail++;
        $display("FAIL skew t=%0d: got v=%b pend=%0d busy=%b, want v=%b pend=%0d busy=%b",
                 t, if_skw.out_valid, if_skw.pending, if_skw.busy, evv, ep, ep != 0);
      end
      for (int c = 0; c < 4; c++) begin
        logic [7:0] ed;
        ed = evv[c] ? 8'(8'hA0 + c) : 8'h00;
        n_chk++;
        if (if_skw.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL skew_data t=%0d lane %0d: got %h want %h", t, c, if_skw.out_data[c], ed);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int a = 0;
    do_reset();
    for (int t = 0; t < 13; t++) begin
      logic er;
      er = t < 6 || t > 8;
      if_des.in_valid = 4'hF;
      if_des.out_ready = er;
      for (int c = 0; c < 4; c++) if_des.in_data[c] = 8'(16 * c + a);
      #1;
      n_chk++;
      if (if_des.in_ready !== er) begin
        n_fail++;
        $display("FAIL bp_ready t=%0d: got %b want %b", t, if_des.in_ready, er);
      end
      for (int c = 0; c < 4; c++) begin
        int src;
        logic ev;
        logic [7:0] ed;
        src = a - dly(c, 0, 1);
        ev = src >= 0;
        ed = ev ? 8'(16 * c + src) : 8'h00;
        n_chk++;
        if (if_des.out_valid[c] !== ev || if_des.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL bp t=%0d lane %0d: got v=%b d=%h, want v=%b d=%h",
                   t, c, if_des.out_valid[c], if_des.out_data[c], ev, ed);
        end
      end
      n_chk++;
      if (if_des.pending !== 5'(exp_pend(a, 100, 0, 1))) begin
        n_fail++;
        $display("FAIL bp_pending t=%0d: got %0d want %0d", t, if_des.pending, exp_pend(a, 100, 0, 1));
      end
      @(posedge clk); #1;
      if (er) a++;
    end
    if_des.out_ready = 1;
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int t = 0; t < 12; t++) begin
      logic [3:0] p;
      p = t[0] ? 4'b1010 : 4'b0101;
      if_des.in_valid = p;
      for (int c = 0; c < 4; c++) if_des.in_data[c] = p[c] ? 8'(16 * c + t) : 8'hEE;
      #1;
      for (int c = 0; c < 4; c++) begin
        int src;
        logic ev;
        logic [7:0] ed;
        src = t - dly(c, 0, 1);
        ev = src >= 0 && (src[0] ? c[0] : !c[0]);
        ed = ev ? 8'(16 * c + src) : 8'h00;
        n_chk++;
        if (if_des.out_valid[c] !== ev || if_des.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL bubble t=%0d lane %0d: got v=%b d=%h, want v=%b d=%h",
                   t, c, if_des.out_valid[c], if_des.out_data[c], ev, ed);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      if_des.in_valid = 4'hF;
      for (int c = 0; c < 4; c++) if_des.in_data[c] = 8'(16 * c + t);
      @(posedge clk); #1;
    end
    n_chk++;
    if (if_des.pending !== 5'd7) begin
      n_fail++;
      $display("FAIL midrst_pre: pending got %0d want 7", if_des.pending);
    end
    resetn = 0;
    @(posedge clk); #1;
    if_des.out_ready = 0;
    #1;
    n_chk++;
    if (if_des.pending !== 5'd0 || if_des.busy !== 1'b0 || if_des.out_valid !== 4'h0 || if_des.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_post: got pend=%0d busy=%b v=%b rdy=%b, want 0 0 0000 1",
               if_des.pending, if_des.busy, if_des.out_valid, if_des.in_ready);
    end
    resetn = 1;
    if_des.out_ready = 1;
    for (int t = 0; t < 6; t++) begin
      if_des.in_valid = 4'hF;
      for (int c = 0; c < 4; c++) if_des.in_data[c] = 8'(8'h80 + 16 * c + t);
      #1;
      for (int c = 0; c < 4; c++) begin
        int src;
        logic ev;
        logic [7:0] ed;
        src = t - dly(c, 0, 1);
        ev = src >= 0;
        ed = ev ? 8'(8'h80 + 16 * c + src) : 8'h00;
        n_chk++;
        if (if_des.out_valid[c] !== ev || if_des.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL midrst_stream t=%0d lane %0d: got v=%b d=%h, want v=%b d=%h",
                   t, c, if_des.out_valid[c], if_des.out_data[c], ev, ed);
        end
      end
      n_chk++;
      if (if_des.pending !== 5'(exp_pend(t, 100, 0, 1))) begin
        n_fail++;
        $display("FAIL midrst_pending t=%0d: got %0d want %0d", t, if_des.pending, exp_pend(t, 100, 0, 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_base3();
    do_reset();
    for (int t = 0; t < 18; t++) begin
      logic eb;
      if_b3.in_valid = t < 10 ? 4'hF : 4'h0;
      for (int c = 0; c < 4; c++) if_b3.in_data[c] = 8'(16 * c + t);
      #1;
      for (int c = 0; c < 4; c++) begin
        int src;
        logic ev;
        logic [7:0] ed;
        src = t - dly(c, 0, 3);
        ev = src >= 0 && src < 10;
        ed = ev ? 8'(16 * c + src) : 8'h00;
        n_chk++;
        if (if_b3.out_valid[c] !== ev || if_b3.out_data[c] !== ed) begin
          n_fail++;
          $display("FAIL drain t=%0d lane %0d: got v=%b d=%h, want v=%b d=%h",
                   t, c, if_b3.out_valid[c], if_b3.out_data[c], ev, ed);
        end
      end
      eb = t >= 1 && t <= 15;
      n_chk++;
      if (if_b3.pending !== 5'(exp_pend(t, 10, 0, 3)) || if_b3.busy !== eb) begin
        n_fail++;
        $display("FAIL drain_busy t=%0d: got pend=%0d busy=%b, want pend=%0d busy=%b",
                 t, if_b3.pending, if_b3.busy, exp_pend(t, 10, 0, 3), eb);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_deskew_stream();
    test_skew_single();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_drain_base3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
